// File: rtl/tag_directory_lru_pkg.sv
// ---------------------------------------------------------------------------
// tag_directory_lru_pkg
// Shared defaults and per-entry age-update predicates for the LRU tag
// directory. Each predicate answers "does this entry's age move?" for one
// of the three same-cycle events (touch, evict, allocate). Ages are passed
// as int unsigned so the same helpers serve any INDEX_WIDTH.
// ---------------------------------------------------------------------------
package tag_directory_lru_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   // Touch: entries younger than the hit entry age by one.
   function automatic logic touch_bump(input logic v, input int unsigned age,
                                       input int unsigned hit_age);
      return v && (age < hit_age);
   endfunction

   // Evict: entries older than the evicted entry close the gap.
   function automatic logic evict_drop(input logic v, input int unsigned age,
                                       input int unsigned ev_age);
      return v && (age > ev_age);
   endfunction

   // Allocate: if the target is free every valid entry ages; if the target
   // is still valid (LRU replacement) only entries younger than it age, which
   // keeps the ages a dense permutation even after an earlier touch/evict.
   function automatic logic alloc_bump(input logic v, input logic is_target,
                                       input logic target_valid,
                                       input int unsigned age,
                                       input int unsigned target_age);
      return v && !is_target && (!target_valid || (age < target_age));
   endfunction

endpackage

// File: rtl/tag_directory_lru_first_one_index.sv
// ---------------------------------------------------------------------------
// first_one_index
// Lowest-set-bit encoder.
//   vec   : request vector
//   any   : at least one bit of vec set
//   index : position of the lowest set bit (0 when vec is all zero)
// ---------------------------------------------------------------------------
module first_one_index #(
   parameter int N  = 16,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec,
   output logic          any,
   output logic [IW-1:0] index
);

   always_comb begin
      any   = |vec;
      index = '0;
      // Scan from the top so the lowest set bit is written last.
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) index = IW'(i);
      end
   end

endmodule

// File: rtl/tag_directory_lru.sv
// ---------------------------------------------------------------------------
// tag_directory_lru
// Fully-associative tag directory with LRU replacement. Allocation never
// stalls: when full, the oldest entry is overwritten and its tag is reported
// on replace_tag so the owner can release the associated resource.
//
// Ports
//   clock, resetn            : clock, asynchronous active-low reset
//   full, empty              : registered occupancy flags
//   allocate_enable/_tag     : allocate a tag this cycle
//   allocate_index           : slot the allocation takes (combinational)
//   replace_valid/_tag       : allocation overwrites a valid entry / its tag
//   search_enable/_tag       : search; a hit with search_enable promotes to MRU
//   search_hit/_index        : lowest-index valid match
//   evict_enable/_index      : invalidate one entry
//
// Configuration macro TAG_DIRECTORY_LRU_SEARCH_REGISTERED_EN: when defined,
// search_hit/search_index are registered (one cycle latency); otherwise they
// are combinational from the current state.
//
// Same-cycle events compose touch -> evict -> allocate. The allocation
// target and full status are taken from the pre-cycle state.
// ---------------------------------------------------------------------------
module tag_directory_lru
   import tag_directory_lru_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   resetn,
   output logic                   full,
   output logic                   empty,
   input  logic                   allocate_enable,
   input  logic [WIDTH-1:0]       allocate_tag,
   output logic [INDEX_WIDTH-1:0] allocate_index,
   output logic                   replace_valid,
   output logic [WIDTH-1:0]       replace_tag,
   input  logic                   search_enable,
   input  logic [WIDTH-1:0]       search_tag,
   output logic                   search_hit,
   output logic [INDEX_WIDTH-1:0] search_index,
   input  logic                   evict_enable,
   input  logic [INDEX_WIDTH-1:0] evict_index
);

   logic [DEPTH-1:0]                  valid_q, valid_b, valid_n;
   logic [DEPTH-1:0][WIDTH-1:0]       tag_q, tag_n;
   logic [DEPTH-1:0][INDEX_WIDTH-1:0] age_q, age_a, age_b, age_n;
   logic                              full_q, empty_q;

   logic [DEPTH-1:0]       match_vec, free_vec;
   logic                   hit_any, free_any;
   logic [INDEX_WIDTH-1:0] hit_idx, free_idx, lru_idx;
   logic [INDEX_WIDTH-1:0] hit_age, ev_age, tgt_age;
   logic                   tgt_valid, evict_ok;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         match_vec[i] = valid_q[i] && (tag_q[i] == search_tag);
      end
      free_vec = ~valid_q;
   end

   first_one_index #(.N(DEPTH), .IW(INDEX_WIDTH)) u_hit_sel (
      .vec   (match_vec),
      .any   (hit_any),
      .index (hit_idx)
   );

   first_one_index #(.N(DEPTH), .IW(INDEX_WIDTH)) u_free_sel (
      .vec   (free_vec),
      .any   (free_any),
      .index (free_idx)
   );

   // When full the ages are exactly 0..DEPTH-1, so one entry holds DEPTH-1.
   always_comb begin
      lru_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (age_q[i] == INDEX_WIDTH'(DEPTH - 1))) lru_idx = INDEX_WIDTH'(i);
      end
   end

   assign allocate_index = (full_q || !free_any) ? lru_idx : free_idx;
   assign replace_valid  = full_q;
   assign replace_tag    = full_q ? tag_q[lru_idx] : '0;

   always_comb begin
      // touch
      age_a   = age_q;
      hit_age = age_q[hit_idx];
      if (search_enable && hit_any) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (touch_bump(valid_q[j], 32'(age_q[j]), 32'(hit_age)))
               age_a[j] = age_q[j] + INDEX_WIDTH'(1);
         end
         age_a[hit_idx] = '0;
      end

      // evict (no-op on an invalid or out-of-range entry)
      valid_b  = valid_q;
      age_b    = age_a;
      evict_ok = (32'(evict_index) < DEPTH);
      ev_age   = evict_ok ? age_a[evict_index] : '0;
      if (evict_enable && evict_ok && valid_q[evict_index]) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (evict_drop(valid_q[j], 32'(age_a[j]), 32'(ev_age)))
               age_b[j] = age_a[j] - INDEX_WIDTH'(1);
         end
         valid_b[evict_index] = 1'b0;
      end

      // allocate (target chosen from pre-cycle state; wins over a same-slot evict)
      valid_n   = valid_b;
      age_n     = age_b;
      tag_n     = tag_q;
      tgt_valid = valid_b[allocate_index];
      tgt_age   = age_b[allocate_index];
      if (allocate_enable) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (alloc_bump(valid_b[j], INDEX_WIDTH'(j) == allocate_index, tgt_valid,
                           32'(age_b[j]), 32'(tgt_age)))
               age_n[j] = age_b[j] + INDEX_WIDTH'(1);
         end
         valid_n[allocate_index] = 1'b1;
         tag_n[allocate_index]   = allocate_tag;
         age_n[allocate_index]   = '0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         valid_q <= '0;
         tag_q   <= '0;
         age_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         valid_q <= valid_n;
         tag_q   <= tag_n;
         age_q   <= age_n;
         full_q  <= &valid_n;
         empty_q <= ~|valid_n;
      end
   end

   assign full  = full_q;
   assign empty = empty_q;

`ifdef TAG_DIRECTORY_LRU_SEARCH_REGISTERED_EN
   logic                   search_hit_q;
   logic [INDEX_WIDTH-1:0] search_index_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         search_hit_q   <= 1'b0;
         search_index_q <= '0;
      end else begin
         search_hit_q   <= hit_any;
         search_index_q <= hit_idx;
      end
   end

   assign search_hit   = search_hit_q;
   assign search_index = search_index_q;
`else
   assign search_hit   = hit_any;
   assign search_index = hit_idx;
`endif

endmodule

// File: tb/tb_tag_directory_lru.sv
// ---------------------------------------------------------------------------
// tb_tag_directory_lru
// Directed scoreboard bench. The stimulus process drives one cycle at a time
// and queues the expected value of an output together with the cycle in which
// it must be observed; a monitor on the falling edge pops and compares every
// entry due in the current cycle. Search expectations move one cycle later
// when TAG_DIRECTORY_LRU_SEARCH_REGISTERED_EN is defined.
// ---------------------------------------------------------------------------
module tb_tag_directory_lru;

`ifdef TAG_DIRECTORY_LRU_SEARCH_REGISTERED_EN
   localparam int SDLY = 1;
`else
   localparam int SDLY = 0;
`endif

   localparam int S_FULL = 0, S_EMPTY = 1, S_HIT = 2, S_SIDX = 3,
                  S_AIDX = 4, S_RVLD = 5, S_RTAG = 6;

   logic       clock = 1'b0;
   logic       resetn;
   logic       full, empty;
   logic       allocate_enable;
   logic [7:0] allocate_tag;
   logic [3:0] allocate_index;
   logic       replace_valid;
   logic [7:0] replace_tag;
   logic       search_enable;
   logic [7:0] search_tag;
   logic       search_hit;
   logic [3:0] search_index;
   logic       evict_enable;
   logic [3:0] evict_index;

   tag_directory_lru #(.WIDTH(8), .DEPTH(16)) dut (
      .clock           (clock),
      .resetn          (resetn),
      .full            (full),
      .empty           (empty),
      .allocate_enable (allocate_enable),
      .allocate_tag    (allocate_tag),
      .allocate_index  (allocate_index),
      .replace_valid   (replace_valid),
      .replace_tag     (replace_tag),
      .search_enable   (search_enable),
      .search_tag      (search_tag),
      .search_hit      (search_hit),
      .search_index    (search_index),
      .evict_enable    (evict_enable),
      .evict_index     (evict_index)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [31:0] probe(input int sel);
      case (sel)
         S_FULL:  return 32'(full);
         S_EMPTY: return 32'(empty);
         S_HIT:   return 32'(search_hit);
         S_SIDX:  return 32'(search_index);
         S_AIDX:  return 32'(allocate_index);
         S_RVLD:  return 32'(replace_valid);
         default: return 32'(replace_tag);
      endcase
   endfunction

   // Monitor: compare everything due this cycle; anything overdue is an error.
   always @(negedge clock) begin
      for (int k = q.size() - 1; k >= 0; k--) begin
         if (q[k].cyc == cyc) begin
            logic [31:0] got;
            got = probe(q[k].sel);
            checks++;
            if (got !== q[k].val) begin
               errors++;
               $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                        q[k].name, got, q[k].val, cyc);
            end
            q.delete(k);
         end else if (q[k].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: never sampled, expected %0h (cycle %0d)",
                     q[k].name, q[k].val, q[k].cyc);
            q.delete(k);
         end
      end
   end

   task automatic chk(input int c, input int sel, input int val, input string name);
      exp_t e;
      e.cyc  = c;
      e.sel  = sel;
      e.val  = 32'(val);
      e.name = name;
      q.push_back(e);
   endtask

   task automatic exp_search(input int h, input int idx, input string name);
      chk(cyc + SDLY, S_HIT, h, {name, "_hit"});
      chk(cyc + SDLY, S_SIDX, idx, {name, "_idx"});
   endtask

   task automatic drive(input logic ae, input logic [7:0] at, input logic se,
                        input logic [7:0] st, input logic ee, input logic [3:0] ei);
      allocate_enable = ae;
      allocate_tag    = at;
      search_enable   = se;
      search_tag      = st;
      evict_enable    = ee;
      evict_index     = ei;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      resetn = 1'b0;
      drive(0, 8'h00, 0, 8'h00, 0, 4'd0);
      tick();
      chk(cyc, S_FULL, 0, "rst_full");
      chk(cyc, S_EMPTY, 1, "rst_empty");
      chk(cyc, S_HIT, 0, "rst_hit");
      chk(cyc, S_SIDX, 0, "rst_sidx");
      tick();
      resetn = 1'b1;

      // Fill 0x10..0x1F into slots 0..15; previous tag must already be searchable.
      for (int i = 0; i < 16; i++) begin
         drive(1, 8'(8'h10 + i), 0, 8'(8'h10 + i - 1), 0, 4'd0);
         chk(cyc, S_AIDX, i, "fill_aidx");
         chk(cyc, S_RVLD, 0, "fill_rvld");
         if (i > 0)  exp_search(1, i - 1, "fill_srch");
         if (i == 0) chk(cyc, S_EMPTY, 1, "fill_empty0");
         if (i == 15) chk(cyc, S_FULL, 0, "fill_notfull15");
         tick();
      end
      drive(0, 8'h00, 0, 8'h00, 0, 4'd0);
      chk(cyc, S_FULL, 1, "fill_full");
      chk(cyc, S_EMPTY, 0, "fill_notempty");

      // Full: replaces LRU slot 0 (0x10).
      drive(1, 8'hAA, 0, 8'h00, 0, 4'd0);
      chk(cyc, S_AIDX, 0, "repl0_aidx");
      chk(cyc, S_RVLD, 1, "repl0_rvld");
      chk(cyc, S_RTAG, 8'h10, "repl0_rtag");
      tick();
      drive(0, 8'h00, 0, 8'hAA, 0, 4'd0);
      exp_search(1, 0, "srch_aa");
      tick();
      drive(0, 8'h00, 0, 8'h10, 0, 4'd0);
      exp_search(0, 0, "srch_gone10");
      tick();

      // Promote LRU slot 1 (0x11); next replacement skips to slot 2.
      drive(0, 8'h00, 1, 8'h11, 0, 4'd0);
      exp_search(1, 1, "touch_11");
      tick();
      drive(1, 8'hBB, 0, 8'h00, 0, 4'd0);
      chk(cyc, S_AIDX, 2, "repl_after_touch_aidx");
      chk(cyc, S_RTAG, 8'h12, "repl_after_touch_rtag");
      tick();
      drive(0, 8'h00, 0, 8'hBB, 0, 4'd0);
      exp_search(1, 2, "srch_bb");
      tick();

      // Evict slot 5, refill it, then walk the LRU order (slots 3 then 4).
      drive(0, 8'h00, 0, 8'h00, 1, 4'd5);
      tick();
      drive(1, 8'hCC, 0, 8'h15, 0, 4'd0);
      chk(cyc, S_FULL, 0, "evict5_notfull");
      chk(cyc, S_AIDX, 5, "evict5_aidx");
      chk(cyc, S_RVLD, 0, "evict5_rvld");
      exp_search(0, 0, "srch_gone15");
      tick();
      drive(1, 8'hEE, 0, 8'hCC, 0, 4'd0);
      chk(cyc, S_FULL, 1, "refill_full");
      chk(cyc, S_AIDX, 3, "lru3_aidx");
      chk(cyc, S_RVLD, 1, "lru3_rvld");
      chk(cyc, S_RTAG, 8'h13, "lru3_rtag");
      exp_search(1, 5, "srch_cc");
      tick();
      drive(1, 8'hEF, 0, 8'h00, 0, 4'd0);
      chk(cyc, S_AIDX, 4, "lru4_aidx");
      chk(cyc, S_RTAG, 8'h14, "lru4_rtag");
      tick();

      // Free slots 3,6,7,8; then same-cycle evict 3 + allocate into 3.
      drive(0, 8'h00, 0, 8'h00, 1, 4'd3); tick();
      drive(0, 8'h00, 0, 8'h00, 1, 4'd6); tick();
      drive(0, 8'h00, 0, 8'h00, 1, 4'd7); tick();
      drive(0, 8'h00, 0, 8'h00, 1, 4'd8); tick();
      drive(1, 8'h77, 0, 8'h16, 1, 4'd3);
      chk(cyc, S_FULL, 0, "sameslot_notfull");
      chk(cyc, S_AIDX, 3, "sameslot_aidx");
      chk(cyc, S_RVLD, 0, "sameslot_rvld");
      exp_search(0, 0, "srch_gone16");
      tick();
      drive(1, 8'h77, 0, 8'h77, 0, 4'd0);
      exp_search(1, 3, "sameslot_srch");
      chk(cyc, S_AIDX, 6, "dup_aidx");
      chk(cyc, S_RVLD, 0, "dup_rvld");
      tick();
      drive(1, 8'h88, 0, 8'h77, 0, 4'd0);
      exp_search(1, 3, "dup_lowest");
      chk(cyc, S_AIDX, 7, "a88_aidx");
      tick();
      drive(1, 8'h99, 0, 8'h88, 0, 4'd0);
      exp_search(1, 7, "srch_88");
      chk(cyc, S_AIDX, 8, "a99_aidx");
      chk(cyc, S_RVLD, 0, "a99_rvld");
      chk(cyc, S_FULL, 0, "a99_notfull");
      tick();

      // Full: evict the LRU slot 9 and allocate the same cycle -> allocate wins.
      drive(1, 8'h55, 0, 8'h99, 1, 4'd9);
      chk(cyc, S_FULL, 1, "fullevict_full");
      chk(cyc, S_AIDX, 9, "fullevict_aidx");
      chk(cyc, S_RVLD, 1, "fullevict_rvld");
      chk(cyc, S_RTAG, 8'h19, "fullevict_rtag");
      exp_search(1, 8, "srch_99");
      tick();
      // Full: evict slot 8 while LRU slot 10 is replaced -> one free slot left.
      drive(1, 8'h66, 0, 8'h55, 1, 4'd8);
      chk(cyc, S_FULL, 1, "evict_other_full");
      chk(cyc, S_AIDX, 10, "evict_other_aidx");
      chk(cyc, S_RTAG, 8'h1A, "evict_other_rtag");
      exp_search(1, 9, "srch_55");
      tick();
      drive(1, 8'h67, 0, 8'h1A, 0, 4'd0);
      chk(cyc, S_FULL, 0, "hole_notfull");
      chk(cyc, S_EMPTY, 0, "hole_notempty");
      chk(cyc, S_AIDX, 8, "hole_aidx");
      chk(cyc, S_RVLD, 0, "hole_rvld");
      exp_search(0, 0, "srch_gone1a");
      tick();
      drive(0, 8'h00, 0, 8'h66, 0, 4'd0);
      chk(cyc, S_FULL, 1, "refull");
      exp_search(1, 10, "srch_66");
      tick();
      tick();

      // Asynchronous reset mid-operation wipes everything at once.
      resetn = 1'b0;
      #1;
      chk(cyc, S_FULL, 0, "midrst_full");
      chk(cyc, S_EMPTY, 1, "midrst_empty");
      chk(cyc, S_HIT, 0, "midrst_hit");
      chk(cyc, S_SIDX, 0, "midrst_sidx");
      tick();

      for (int w = 0; w < 5 && q.size() > 0; w++) tick();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d checks still pending, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tag_directory_lru.md
# tag_directory_lru

Fully-associative tag directory with per-entry recency tracking and automatic least-recently-used replacement. Allocation never stalls: when the directory is full, the LRU entry is overwritten and its tag reported so the owner can write back or release the associated resource. A hit on the search port can optionally promote the entry to most-recently-used. Sits in front of small caches, TLBs and outstanding-request trackers where the plain allocate/search/evict directory would need external replacement logic.

## Interface
- WIDTH, 8, tag width in bits
- DEPTH, 16, number of entries (≥2)
- INDEX_WIDTH, $clog2(DEPTH), entry index width
- clock  input  1  single clock, rising edge
- resetn  input  1  asynchronous active-low reset
- full  output  1  all entries valid (registered)
- empty  output  1  no entry valid (registered)
- allocate_enable  input  1  write allocate_tag this cycle
- allocate_tag  input  WIDTH  tag to allocate
- allocate_index  output  INDEX_WIDTH  slot the current allocation will take (combinational)
- replace_valid  output  1  current allocation overwrites a valid entry (combinational)
- replace_tag  output  WIDTH  tag being overwritten (combinational)
- search_enable  input  1  search is active; a hit promotes the entry
- search_tag  input  WIDTH  tag to search
- search_hit  output  1  valid entry matches
- search_index  output  INDEX_WIDTH  matching entry index
- evict_enable  input  1  invalidate entry evict_index
- evict_index  input  INDEX_WIDTH  entry to invalidate

## Operation
- Per entry: valid, tag, age (INDEX_WIDTH bits). Valid entries always hold distinct ages 0..N-1 (N = valid count); age 0 = MRU.
- Search: lowest-index valid entry with tag == search_tag; hit 0 and index 0 on miss. Duplicate tags are legal; lowest index wins.
- Touch (search_enable && hit, entry i): valid entries with age < age[i] increment; age[i] = 0.
- Evict (entry e, valid): valid entries with age > age[e] decrement; valid[e] = 0. Evicting an invalid entry is a no-op.
- Allocate, not full: target = lowest-index invalid entry; replace_valid = 0; all valid entries increment age; target gets tag, valid = 1, age 0.
- Allocate, full: target = entry with age DEPTH-1; replace_valid = 1, replace_tag = its tag; all other entries increment; target gets new tag, age 0.
- allocate_index/replace_* reflect pre-cycle state and are meaningful only when allocate_enable = 1.
- Same-cycle events apply in order touch -> evict -> allocate, each on the result of the previous. Allocation target and full status use pre-cycle state: if full and evict_enable, allocation still replaces the LRU entry (evict still applied); if allocation target == evict_index, allocation wins and entry ends valid at age 0.
- full/empty are registered from the next-state valid vector.

## Timing
- Reset: all valid = 0, tags = 0, ages = 0; full = 0, empty = 1; search_hit = 0, search_index = 0.
- Allocation/eviction/touch visible to search on the cycle after the edge.
- Search latency: combinational (0 cycles) without the configuration macro.
- Reset asserted mid-operation discards all entries immediately; in-flight allocations are lost.

## Configuration
- TAG_DIRECTORY_LRU_SEARCH_REGISTERED_EN defined: search_hit/search_index registered, valid 1 cycle after search_tag is presented; the touch still takes effect at the edge ending the search cycle; outputs reset to 0.
- Undefined: search outputs combinational from current state.

## Structure
- Package tag_directory_lru_pkg: age-update helper functions (touch/evict/allocate age transforms), no typedefs exported beyond a parametrised entry struct is not required.
- Sub-module first_one_index: lowest-set-bit index plus any-set flag, instantiated for free-slot selection and hit selection.

## Test plan
- Reset, allocate tags 0x10..0x1F into DEPTH 16 -> indices 0..15, full = 1 after 16th edge, index 0 has age 15.
- Full, allocate 0xAA -> allocate_index 0, replace_valid 1, replace_tag 0x10; next search 0xAA hits index 0.
- Full, search_enable on 0x10 (index 0), then allocate 0xBB -> replaces index 1 (tag 0x11).
- Evict index 5, then allocate 0xCC -> allocate_index 5, replace_valid 0; ages remain a permutation 0..15.
- Same cycle evict index 3 and allocate with 4 free slots, lowest free 3 -> entry 3 valid with new tag at age 0.
- Macro defined: search 0x12 at cycle t -> search_hit 1, search_index 2 at t+1; 0 after reset.
